// File: rtl/zbt_port_arbiter.sv
// ZBT SRAM port arbiter: buffers capture-stage writes in a small FIFO, gives display
// reads strict priority, and drives the pipelined ZBT bus (write data two cycles after
// address, read data returned to the display three cycles after the request).
module zbt_port_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 36,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_W-1:0]               ntsc_addr,
  input  logic [DATA_W-1:0]               ntsc_data,
  input  logic                            ntsc_we,
  input  logic                            disp_req,
  input  logic [ADDR_W-1:0]               disp_addr,
  output logic [DATA_W-1:0]               disp_data,
  output logic                            disp_valid,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic                            ram_we_b,
  output logic [DATA_W-1:0]               ram_data_out,
  output logic                            ram_data_oe,
  input  logic [DATA_W-1:0]               ram_data_in,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            wr_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  // Capture strobe arrives one cycle ahead of its address/data.
  logic                pend_q;

  // Write FIFO storage and control
  logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [LvlW-1:0]     level_q;
  logic                overflow_q;

  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                drop;

  // Write data phase shift register (two stages ahead of the bus register)
  logic                wv1_q, wv2_q;
  logic [DATA_W-1:0]   wd1_q, wd2_q;

  // Read return shift register
  logic                rv1_q, rv2_q, rv3_q;

  // FIFO status and the push/pop/drop decision for this edge
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
    pop        = !disp_req && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = pend_q && (!fifo_full || pop);
    drop       = pend_q && fifo_full && !pop;
  end

  // Capture pend flag, FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q <= ntsc_we;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (pop && !push) level_q <= level_q - LvlW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= ntsc_addr;
      mem_data[wr_ptr_q] <= ntsc_data;
    end
  end

  // Address phase: display read first, then a buffered write, else idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_we_b <= 1'b1;
    end else if (disp_req) begin
      ram_addr <= disp_addr;
      ram_we_b <= 1'b1;
    end else if (pop) begin
      ram_addr <= mem_addr[rd_ptr_q];
      ram_we_b <= 1'b0;
    end else begin
      ram_we_b <= 1'b1;
    end
  end

  // Write data phase: drive data and enable two edges after the write address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wv1_q        <= 1'b0;
      wv2_q        <= 1'b0;
      wd1_q        <= '0;
      wd2_q        <= '0;
      ram_data_out <= '0;
      ram_data_oe  <= 1'b0;
    end else begin
      wv1_q       <= pop;
      wd1_q       <= mem_data[rd_ptr_q];
      wv2_q       <= wv1_q;
      wd2_q       <= wd1_q;
      ram_data_oe <= wv2_q;
      if (wv2_q) ram_data_out <= wd2_q;
    end
  end

  // Read return: sample the bus three edges after the read address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1_q      <= 1'b0;
      rv2_q      <= 1'b0;
      rv3_q      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rv1_q      <= disp_req;
      rv2_q      <= rv1_q;
      rv3_q      <= rv2_q;
      disp_valid <= rv3_q;
      if (rv3_q) disp_data <= ram_data_in;
    end
  end

  assign fifo_level  = level_q;
  assign wr_overflow = overflow_q;

endmodule
